// File: rtl/core_pkg.sv
// Shared types and constants for the 5-stage core front end.
package core_pkg;

    localparam int unsigned     XLEN   = 32;
    localparam logic [XLEN-1:0] NOP_IR = '0;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } fetch_state_t;

    typedef enum logic [1:0] {
        SC_IDLE    = 2'b00,
        SC_HOLD    = 2'b01,
        SC_RELEASE = 2'b10,
        SC_ILLEGAL = 2'b11
    } stall_cnt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry ir/pc holding register for a fetch response that lands while IF/ID is stalled.
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr,
    input  logic            i_rd_clr,
    input  logic            i_clr,
    input  logic [XLEN-1:0] i_ir,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_full,
    output logic [XLEN-1:0] o_ir,
    output logic [XLEN-1:0] o_pc
);

    logic            r_full;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_ir   <= NOP_IR;
            r_pc   <= '0;
        end else if (i_clr || i_rd_clr) begin
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_full <= 1'b1;
            r_ir   <= i_ir;
            r_pc   <= i_pc;
        end
    end

    assign o_full = r_full;
    assign o_ir   = r_ir;
    assign o_pc   = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single outstanding imem request, IF/ID register and
// the load-interlock stall counter.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic [1:0]  stall_counter
);

    fetch_state_t    r_state,     w_state_nxt;
    stall_cnt_t      r_stall_cnt, w_stall_cnt_nxt;
    logic [XLEN-1:0] r_fetch_pc,  w_fetch_pc_nxt;
    logic [XLEN-1:0] r_req_pc,    w_req_pc_nxt;
    logic [XLEN-1:0] r_if_ir,     w_if_ir_nxt;
    logic [XLEN-1:0] r_if_pc,     w_if_pc_nxt;
    logic            r_if_valid,  w_if_valid_nxt;

    logic            w_req_valid;
    logic            w_accept;
    logic            w_rsp_wait;
    logic            w_outstanding;
    logic [XLEN-1:0] w_redirect_aligned;
    logic            w_skid_wr;
    logic            w_skid_rd;
    logic            w_skid_clr;
    logic            w_skid_full;
    logic [XLEN-1:0] w_skid_ir;
    logic [XLEN-1:0] w_skid_pc;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_wr     (w_skid_wr),
        .i_rd_clr (w_skid_rd),
        .i_clr    (w_skid_clr),
        .i_ir     (imem_rsp_data),
        .i_pc     (r_req_pc),
        .o_full   (w_skid_full),
        .o_ir     (w_skid_ir),
        .o_pc     (w_skid_pc)
    );

    assign w_req_valid        = !rst && (r_state == RUN) && !stall && !w_skid_full;
    assign w_accept           = w_req_valid && imem_req_ready;
    assign w_rsp_wait         = (r_state == WAIT) && imem_rsp_valid;
    assign w_redirect_aligned = redirect_pc & ~32'h3;
    // A response in the redirect cycle retires the old request, so only a still-pending one needs DROP.
    assign w_outstanding      = w_accept ||
                                (((r_state == WAIT) || (r_state == DROP)) && !imem_rsp_valid);

    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_req_pc_nxt    = r_req_pc;
        w_if_ir_nxt     = r_if_ir;
        w_if_pc_nxt     = r_if_pc;
        w_if_valid_nxt  = r_if_valid;
        w_stall_cnt_nxt = SC_IDLE;
        w_skid_wr       = 1'b0;
        w_skid_rd       = 1'b0;
        w_skid_clr      = 1'b0;

        case (r_stall_cnt)
            SC_IDLE:    w_stall_cnt_nxt = stall ? SC_HOLD : SC_IDLE;
            SC_HOLD:    w_stall_cnt_nxt = SC_RELEASE;
            SC_RELEASE: w_stall_cnt_nxt = stall ? SC_HOLD : SC_IDLE;
            default:    w_stall_cnt_nxt = SC_IDLE;
        endcase

        case (r_state)
            RUN: begin
                if (w_accept) begin
                    w_req_pc_nxt   = r_fetch_pc;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_skid_wr   = stall;
                    w_state_nxt = RUN;
                end
            end
            DROP: begin
                if (imem_rsp_valid) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase

        if (!stall) begin
            if (w_skid_full) begin
                w_if_ir_nxt    = w_skid_ir;
                w_if_pc_nxt    = w_skid_pc;
                w_if_valid_nxt = 1'b1;
                w_skid_rd      = 1'b1;
            end else if (w_rsp_wait) begin
                w_if_ir_nxt    = imem_rsp_data;
                w_if_pc_nxt    = r_req_pc;
                w_if_valid_nxt = 1'b1;
            end else begin
                w_if_ir_nxt    = NOP_IR;
                w_if_pc_nxt    = '0;
                w_if_valid_nxt = 1'b0;
            end
        end

        if (redirect_valid) begin
            w_fetch_pc_nxt  = w_redirect_aligned;
            w_if_ir_nxt     = NOP_IR;
            w_if_pc_nxt     = '0;
            w_if_valid_nxt  = 1'b0;
            w_skid_wr       = 1'b0;
            w_skid_rd       = 1'b0;
            w_skid_clr      = 1'b1;
            w_stall_cnt_nxt = SC_IDLE;
            w_state_nxt     = w_outstanding ? DROP : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= SC_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_req_pc    <= '0;
            r_if_ir     <= NOP_IR;
            r_if_pc     <= '0;
            r_if_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_req_pc    <= w_req_pc_nxt;
            r_if_ir     <= w_if_ir_nxt;
            r_if_pc     <= w_if_pc_nxt;
            r_if_valid  <= w_if_valid_nxt;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign if_id_ir       = r_if_ir;
    assign if_id_pc       = r_if_pc;
    assign if_id_valid    = r_if_valid;
    assign stall_counter  = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: scripted imem responses, IF/ID checked on every load.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic [1:0]  stall_counter;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [63:0] sb[$];
    logic        s_stall = 1'b1;
    logic        s_rst   = 1'b1;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_ir       (if_id_ir),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .stall_counter  (stall_counter)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // One zero-wait fetch: accept at pc, respond next cycle, IF/ID loads on the edge after.
    task automatic mem_fetch(input logic [31:0] data, input logic [31:0] pc);
        imem_req_ready = 1'b1;
        settle();
        check_eq("fetch_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check_eq("fetch_req_addr", {32'h0, imem_req_addr}, {32'h0, pc});
        tick();
        check_eq("gap_bubble", {if_id_ir, 31'h0, if_id_valid}, 64'h0);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        sb.push_back({data, pc});
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    always @(posedge clk) begin
        s_stall <= stall;
        s_rst   <= rst;
    end

    always @(negedge clk) begin
        logic [63:0] exp_v;
        if (!s_rst && !s_stall && if_id_valid) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_valid", {63'h0, if_id_valid}, 64'h0);
            end else begin
                exp_v = sb.pop_front();
                check_eq("sb_ifid", {if_id_ir, if_id_pc}, exp_v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Reset
        tick();
        check_eq("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        tick();
        rst = 1'b0;
        settle();
        check_eq("rel_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check_eq("rel_req_addr", {32'h0, imem_req_addr}, 64'h100);
        check_eq("rel_ifid", {if_id_ir, if_id_pc}, 64'h0);
        check_eq("rel_ifid_valid", {63'h0, if_id_valid}, 64'h0);
        check_eq("rel_counter", {62'h0, stall_counter}, 64'h0);

        // Zero-wait memory: two back-to-back instructions
        mem_fetch(32'h00A00093, 32'h100);
        check_eq("zw_ifid0", {if_id_ir, if_id_pc}, {32'h00A00093, 32'h100});
        mem_fetch(32'h00108113, 32'h104);
        check_eq("zw_ifid1", {if_id_ir, if_id_pc}, {32'h00108113, 32'h104});
        check_eq("zw_valid1", {63'h0, if_id_valid}, 64'h1);

        // One-cycle stall: counter sequence and IF/ID hold
        stall = 1'b1;
        imem_req_ready = 1'b1;
        settle();
        check_eq("st_withdraw", {63'h0, imem_req_valid}, 64'h0);
        check_eq("st_cnt0", {62'h0, stall_counter}, 64'h0);
        tick();
        stall = 1'b0;
        imem_req_ready = 1'b0;
        settle();
        check_eq("st_cnt1", {62'h0, stall_counter}, 64'h1);
        check_eq("st_hold", {if_id_ir, if_id_pc}, {32'h00108113, 32'h104});
        check_eq("st_hold_valid", {63'h0, if_id_valid}, 64'h1);
        tick();
        check_eq("st_cnt2", {62'h0, stall_counter}, 64'h2);
        tick();
        check_eq("st_cnt3", {62'h0, stall_counter}, 64'h0);

        // Response lands while stalled: skid capture, then release
        imem_req_ready = 1'b1;
        settle();
        check_eq("sk_req_addr", {32'h0, imem_req_addr}, 64'h108);
        tick();
        imem_req_ready = 1'b0;
        stall          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h00002083;
        sb.push_back({32'h00002083, 32'h108});
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check_eq("sk_no_req_stall", {63'h0, imem_req_valid}, 64'h0);
        check_eq("sk_ifid_held", {63'h0, if_id_valid}, 64'h0);
        stall = 1'b0;
        settle();
        check_eq("sk_no_req_full", {63'h0, imem_req_valid}, 64'h0);
        check_eq("sk_cnt", {62'h0, stall_counter}, 64'h1);
        tick();
        check_eq("sk_ifid", {if_id_ir, if_id_pc}, {32'h00002083, 32'h108});
        check_eq("sk_cnt2", {62'h0, stall_counter}, 64'h2);
        check_eq("sk_req_after", {63'h0, imem_req_valid}, 64'h1);

        // Redirect while WAIT: late response must be dropped
        imem_req_ready = 1'b1;
        settle();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEADBEEF;
        settle();
        check_eq("rd_drop_no_req", {63'h0, imem_req_valid}, 64'h0);
        check_eq("rd_bubble0", {if_id_ir, 31'h0, if_id_valid}, 64'h0);
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check_eq("rd_bubble1", {if_id_ir, 31'h0, if_id_valid}, 64'h0);
        check_eq("rd_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check_eq("rd_req_addr", {32'h0, imem_req_addr}, 64'h200);

        // Redirect together with stall while counter is 01
        mem_fetch(32'h00300193, 32'h200);
        stall = 1'b1;
        settle();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        settle();
        check_eq("rs_cnt_pre", {62'h0, stall_counter}, 64'h1);
        check_eq("rs_held_valid", {63'h0, if_id_valid}, 64'h1);
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        settle();
        check_eq("rs_cnt", {62'h0, stall_counter}, 64'h0);
        check_eq("rs_bubble", {if_id_ir, if_id_pc}, 64'h0);
        check_eq("rs_bubble_valid", {63'h0, if_id_valid}, 64'h0);
        check_eq("rs_req_addr", {32'h0, imem_req_addr}, 64'h300);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        mem_fetch(32'h00400213, 32'hFFFF_FFFC);
        settle();
        check_eq("wrap_addr", {32'h0, imem_req_addr}, 64'h0);

        // Reset in WAIT, then a stray response must be ignored
        imem_req_ready = 1'b1;
        settle();
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check_eq("rw_req_valid", {63'h0, imem_req_valid}, 64'h1);
        check_eq("rw_req_addr", {32'h0, imem_req_addr}, 64'h100);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BADF00D;
        tick();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        settle();
        check_eq("rw_stray", {if_id_ir, 31'h0, if_id_valid}, 64'h0);
        check_eq("rw_req_after", {63'h0, imem_req_valid}, 64'h1);
        tick();

        check_eq("sb_drained", {32'h0, sb.size()}, 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
